// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU, with a registered response slot per port.
// Optional saturating grant/conflict counters are enabled with `define ALU_ARB_STATS_EN.
//
// Response slot state (one per port):
//   state      | meaning
//   SLOT_EMPTY | no response held, port may be granted
//   SLOT_FULL  | response held until rspN_ready; refilled in the same cycle if granted

module alu_arbiter #(
  parameter int WIDTH      = 16,
  parameter int OPW        = 3,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_grant0,
  output logic [CNT_W-1:0] stat_grant1,
  output logic [CNT_W-1:0] stat_conflict
`endif
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

  slot_t slot0_q, slot0_d;
  slot_t slot1_q, slot1_d;
  logic  rr_ptr_q, rr_ptr_d;
  logic  elig0, elig1;
  logic  grant0, grant1;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q  <= SLOT_EMPTY;
      slot1_q  <= SLOT_EMPTY;
      rr_ptr_q <= 1'b0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    rr_ptr_d = rr_ptr_q;
    grant0   = 1'b0;
    grant1   = 1'b0;

    // A full slot being drained this cycle counts as free.
    elig0 = req0_valid && ((slot0_q == SLOT_EMPTY) || rsp0_ready);
    elig1 = req1_valid && ((slot1_q == SLOT_EMPTY) || rsp1_ready);

    if (elig0 && elig1) begin
      if ((FIXED_PRIO != 0) || !rr_ptr_q) grant0 = 1'b1;
      else                                 grant1 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end

    if (grant0)      rr_ptr_d = 1'b1;
    else if (grant1) rr_ptr_d = 1'b0;

    if (grant0)          slot0_d = SLOT_FULL;
    else if (rsp0_ready) slot0_d = SLOT_EMPTY;

    if (grant1)          slot1_d = SLOT_FULL;
    else if (rsp1_ready) slot1_d = SLOT_EMPTY;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (slot0_q == SLOT_FULL);
  assign rsp1_valid = (slot1_q == SLOT_FULL);

  // Idle cycles present port 0's operands so the ALU never sees X.
  assign alu_a       = grant1 ? req1_a  : req0_a;
  assign alu_b       = grant1 ? req1_b  : req0_b;
  assign alu_control = grant1 ? req1_op : req0_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      if (grant0) begin
        rsp0_result <= alu_result;
        rsp0_zero   <= alu_zero;
      end
      if (grant1) begin
        rsp1_result <= alu_result;
        rsp1_zero   <= alu_zero;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0 && (stat_grant0 != '1))            stat_grant0   <= stat_grant0 + CNT_W'(1);
      if (grant1 && (stat_grant1 != '1))            stat_grant1   <= stat_grant1 + CNT_W'(1);
      if (elig0 && elig1 && (stat_conflict != '1))  stat_conflict <= stat_conflict + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU model, per-port response scoreboard and scenario tasks.
// Counter checks are compiled in when ALU_ARB_STATS_EN is defined.

module tb_alu_arbiter;
  localparam int W   = 16;
  localparam int OPW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0_valid = 0, req1_valid = 0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [OPW-1:0] req0_op = 0, req1_op = 0;
  logic           rsp0_valid, rsp1_valid;
  logic           rsp0_ready = 0, rsp1_ready = 0;
  logic [W-1:0]   rsp0_result, rsp1_result;
  logic           rsp0_zero, rsp1_zero;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [OPW-1:0] alu_control;
  logic           alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]    stat_grant0, stat_grant1, stat_conflict;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // Behavioural ALU: 010 subtracts, every other code adds.
  always_comb begin
    alu_result = (alu_control == 3'b010) ? alu_a - alu_b : alu_a + alu_b;
    alu_zero   = (alu_result == '0);
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
    exp_t e;
    e.res = (op == 3'b010) ? a - b : a + b;
    e.z   = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle; responses popped before new requests pushed.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL sb0_underflow: got result=%h with nothing expected", rsp0_result);
        end else begin
          e = q0.pop_front();
          if (rsp0_result !== e.res || rsp0_zero !== e.z) begin
            bad++;
            $display("FAIL sb0_data: got %h/%b want %h/%b", rsp0_result, rsp0_zero, e.res, e.z);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sb1_underflow: got result=%h with nothing expected", rsp1_result);
        end else begin
          e = q1.pop_front();
          if (rsp1_result !== e.res || rsp1_zero !== e.z) begin
            bad++;
            $display("FAIL sb1_data: got %h/%b want %h/%b", rsp1_result, rsp1_zero, e.res, e.z);
          end
        end
      end
      if (req0_valid && req0_ready) q0.push_back(model(req0_a, req0_b, req0_op));
      if (req1_valid && req1_ready) q1.push_back(model(req1_a, req1_b, req1_op));
    end
  end

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    total++; if (rsp0_result !== 16'h0 || rsp1_result !== 16'h0) begin bad++; $display("FAIL reset_result: got %h %h want 0 0", rsp0_result, rsp1_result); end
    total++; if (rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b%b want 00", rsp0_zero, rsp1_zero); end
  endtask

  task automatic test_single;
    @(negedge clk);
    rsp0_ready = 1;
    drive0(1, 16'h0005, 16'h0003, 3'b001);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready); end
    total++; if (alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_control !== 3'b001) begin bad++; $display("FAIL single_alu_drive: got %h %h %b want 0005 0003 001", alu_a, alu_b, alu_control); end
    @(negedge clk);
    drive0(1, 16'h0007, 16'h0007, 3'b010);
    #1;
    total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0008 || rsp0_zero !== 1'b0) begin bad++; $display("FAIL single_add: got %b %h %b want 1 0008 0", rsp0_valid, rsp0_result, rsp0_zero); end
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_refill_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    drive0(0, 0, 0, 0);
    #1;
    total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0000 || rsp0_zero !== 1'b1) begin bad++; $display("FAIL single_sub_zero: got %b %h %b want 1 0000 1", rsp0_valid, rsp0_result, rsp0_zero); end
    @(negedge clk); #1;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rsp1_ready = 1;
    drive1(1, 16'hFFFF, 16'h0001, 3'b001);
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL wrap_grant: got %b want 1", req1_ready); end
    @(negedge clk);
    drive1(1, 16'h0000, 16'h0001, 3'b010);
    #1;
    total++; if (rsp1_result !== 16'h0000 || rsp1_zero !== 1'b1) begin bad++; $display("FAIL wrap_add: got %h %b want 0000 1", rsp1_result, rsp1_zero); end
    @(negedge clk);
    drive1(0, 0, 0, 0);
    #1;
    total++; if (rsp1_result !== 16'hFFFF || rsp1_zero !== 1'b0) begin bad++; $display("FAIL wrap_sub: got %h %b want ffff 0", rsp1_result, rsp1_zero); end
    @(negedge clk);
  endtask

  task automatic test_conflict;
    logic want0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef ALU_ARB_STATS_EN
    #1;
    total++; if (stat_grant0 !== 16'd0 || stat_grant1 !== 16'd0 || stat_conflict !== 16'd0) begin bad++; $display("FAIL stats_reset: got %0d %0d %0d want 0 0 0", stat_grant0, stat_grant1, stat_conflict); end
`endif
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive0(1, W'(i * 3), 16'h0001, 3'b001);
      drive1(1, W'(100 + i), W'(i), 3'b010);
      #1;
      want0 = ((i % 2) == 0);
      total++;
      if (req0_ready !== want0 || req1_ready !== !want0) begin
        bad++;
        $display("FAIL conflict_rr[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, want0, !want0);
      end
    end
    @(negedge clk);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    @(negedge clk); #1;
`ifdef ALU_ARB_STATS_EN
    total++; if (stat_conflict !== 16'd4) begin bad++; $display("FAIL stats_conflict: got %0d want 4", stat_conflict); end
    total++; if (stat_grant0 !== 16'd2 || stat_grant1 !== 16'd2) begin bad++; $display("FAIL stats_grants: got %0d %0d want 2 2", stat_grant0, stat_grant1); end
`endif
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 1;
    drive0(1, 16'h0010, 16'h0020, 3'b001);
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_first_grant: got %b want 1", req0_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive0(1, 16'h0030, 16'h0001, 3'b001);
      drive1(1, W'(16'h0200 + i), W'(i), 3'b001);
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL bp_grant[%0d]: got %b%b want 01", i, req0_ready, req1_ready); end
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0030) begin bad++; $display("FAIL bp_hold[%0d]: got %b %h want 1 0030", i, rsp0_valid, rsp0_result); end
    end
    @(negedge clk);
    drive1(0, 0, 0, 0);
    rsp0_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_refill_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    drive0(0, 0, 0, 0);
    #1;
    total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0031) begin bad++; $display("FAIL bp_no_bubble: got %b %h want 1 0031", rsp0_valid, rsp0_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    drive0(1, 16'h0001, 16'h0001, 3'b001);
    drive1(1, 16'h0003, 16'h0004, 3'b001);
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL mid_rr: got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_bp1: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 16'h0007) begin bad++; $display("FAIL mid_pending: got %b %h want 1 0007", rsp1_valid, rsp1_result); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL mid_discard: got %b%b want 00", rsp0_valid, rsp1_valid); end
`ifdef ALU_ARB_STATS_EN
    total++; if (stat_grant0 !== 16'd0 || stat_grant1 !== 16'd0 || stat_conflict !== 16'd0) begin bad++; $display("FAIL stats_mid_reset: got %0d %0d %0d want 0 0 0", stat_grant0, stat_grant1, stat_conflict); end
`endif
    @(negedge clk);
    rsp0_ready = 1; rsp1_ready = 1;
    drive0(1, 16'h0009, 16'h0009, 3'b010);
    drive1(1, 16'h0002, 16'h0002, 3'b001);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_ptr_reset: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL mid_ptr_next: got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_conflict();
    test_backpressure();
    test_reset_mid();
    @(negedge clk); #3;
    total++; if (q0.size() != 0 || q1.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d/%0d entries want 0/0", q0.size(), q1.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters: port 0 is the execute stage, port 1 is the branch/address-calculation unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block selects one requester per cycle and drives the ALU operand and function-select inputs with that request.
- It captures the ALU result and zero flag into a per-port response register.

Parameters:
- WIDTH, 16, operand/result width
- OPW, 3, ALU function-select width (001 add, 010 sub, others add)
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins
- CNT_W, 16, statistics counter width (only used with ALU_ARB_STATS_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OPW  ALU function select
- rsp0_valid / rsp1_valid  out  1  response register holds data
- rsp0_ready / rsp1_ready  in  1  consumer takes response
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag
- alu_a, alu_b  out  WIDTH  to ALU operands
- alu_control  out  OPW  to ALU function select
- alu_result  in  WIDTH  from ALU (combinational, same cycle)
- alu_zero  in  1  from ALU

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: rspN_valid=0, rspN_result=0, rspN_zero=0, RR pointer=0 (port 0 preferred first).
- Eligibility: port N is eligible when reqN_valid=1 and its response slot is free, i.e. rspN_valid=0 or rspN_ready=1 in the same cycle (drain-and-refill allowed).
- Grant, exactly one eligible port: that port is granted.
- Grant, both eligible:
  - FIXED_PRIO=0: the port named by the RR pointer wins.
  - FIXED_PRIO=1: port 0 always wins.
- Ready outputs: reqN_ready=1 only for the granted port, same cycle. It is combinational from valid, rsp state and pointer.
- ALU drive: alu_a/alu_b/alu_control = granted port's operands/op. When idle they hold port 0's inputs, so there is no X propagation.
- Latency: a request accepted at edge N produces rspN_valid=1 with result/zero after edge N. One-cycle latency; throughput one op per cycle total.
- RR pointer update: after a grant, the pointer points to the non-granted port. With no grant the pointer is unchanged.
- Response hold: rspN_valid stays set, with data stable, until rspN_ready=1. On rspN_ready with no new grant, rspN_valid clears; data may hold its last value.
- Arithmetic: wrap modulo 2^WIDTH. Zero is taken from alu_zero and is not recomputed.
- Backpressure: while rspN_valid=1 and rspN_ready=0, reqN_ready=0. The other port may still be granted every cycle.
- Reset mid-operation: pending responses are discarded, valids drop next edge, and the pointer returns to 0. Requesters must re-issue.
- The block has no internal FSM beyond the RR pointer and two response-slot flags (EMPTY/FULL per port):
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready without grant.
  - FULL→FULL on rsp_ready with grant (new data).

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds outputs stat_grant0, stat_grant1 and stat_conflict (CNT_W each).
  - stat_grant0/stat_grant1 count grants per port.
  - stat_conflict counts cycles where both ports were eligible.
  - All counters saturate at all-ones and clear on reset.
- Not defined: those ports and counters do not exist, and arbitration is identical in both builds.

Test Plan:
- Reset then idle: rsp0_valid=rsp1_valid=0, both reqN_ready=0, results 0.
- Single request: port 0 sends 0x0005,0x0003,op=001 with rsp0_ready=1. Required: req0_ready=1, next cycle rsp0_result=0x0008, rsp0_zero=0. Then port 0 sends op=010, 7,7 → result 0x0000, zero=1.
- Wrap-around: port 1 sends 0xFFFF+0x0001, op=001 → rsp1_result=0x0000, rsp1_zero=1. Port 1 sends 0x0000-0x0001, op=010 → 0xFFFF.
- Conflict, FIXED_PRIO=0: both valid for 4 cycles with rsp ready held 1 → grants alternate 0,1,0,1. Port 0 gets the first grant after reset.
- Backpressure: rsp0_ready=0 after one port 0 response → req0_ready stays 0 and rsp0_result is stable. Port 1 is granted every cycle meanwhile. Raising rsp0_ready with req0_valid high gives drain-and-refill in the same cycle, with no bubble.
- Reset mid-operation: assert reset while rsp1_valid=1 → rsp1_valid=0 next edge. With ALU_ARB_STATS_EN, all counters read 0 after reset and stat_conflict=4 after the conflict test.
